// File: rtl/tankb_pkg.sv
// Shared definitions for the Tank B video RAM arbiter.
package tankb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_VID  = 2'd2
    } gnt_e;

    localparam logic [15:0] WIN_BASE_DEF = 16'h8000;

endpackage

// File: rtl/tankb_rr_arb2.sv
// Two-way arbiter between the CPU pending slot and the video fetch engine.
// With contention it alternates, or always favours video when VID_FIXED_PRI=1.
module tankb_rr_arb2
    import tankb_pkg::*;
#(
    parameter bit VID_FIXED_PRI = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_cpu,
    input  logic i_req_vid,
    output gnt_e o_gnt
);

    gnt_e r_last_grant;
    gnt_e w_gnt;

    // Grant selection for the current RAM cycle
    always_comb begin
        w_gnt = GNT_NONE;
        case ({i_req_cpu, i_req_vid})
            2'b10:   w_gnt = GNT_CPU;
            2'b01:   w_gnt = GNT_VID;
            2'b11: begin
                if (VID_FIXED_PRI) begin
                    w_gnt = GNT_VID;
                end else if (r_last_grant == GNT_VID) begin
                    w_gnt = GNT_CPU;
                end else begin
                    w_gnt = GNT_VID;
                end
            end
            default: w_gnt = GNT_NONE;
        endcase
    end

    // Remember the most recent winner for round-robin fairness
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GNT_CPU;
        end else if (w_gnt != GNT_NONE) begin
            r_last_grant <= w_gnt;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/tankb_vram_arbiter.sv
// Shares one single-port synchronous RAM between the 6502 bus and video fetch.
// CPU accesses are parked in a pending slot and the CPU is stalled via cpu_rdy.
module tankb_vram_arbiter
    import tankb_pkg::*;
#(
    parameter int          ADDR_W        = 10,
    parameter logic [15:0] WIN_BASE      = WIN_BASE_DEF,
    parameter bit          VID_FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_clken,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_cs,
    output logic              cpu_rdy,
    output logic              cpu_ovr,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [7:0]        vid_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_pend_we;
    logic [7:0]        r_pend_wdata;
    gnt_e              r_tag;
    logic              r_cpu_rdy;
    logic              r_cpu_ovr;
    logic [7:0]        r_cpu_din;
    logic              r_vid_valid;
    logic [7:0]        r_vid_data;

    logic              w_cpu_cs;
    logic              w_capture;
    logic              w_overrun;
    logic              w_req_vid;
    gnt_e              w_gnt;

    assign w_cpu_cs  = (cpu_addr[15:ADDR_W] == WIN_BASE[15:ADDR_W]);
    assign w_capture = cpu_clken & w_cpu_cs & r_cpu_rdy;
    assign w_overrun = cpu_clken & w_cpu_cs & ~r_cpu_rdy;
    // Video is masked during reset so no RAM cycle starts while it is held.
    assign w_req_vid = vid_req & ~reset;

    tankb_rr_arb2 #(
        .VID_FIXED_PRI(VID_FIXED_PRI)
    ) u_arb (
        .clk      (clk),
        .rst      (reset),
        .i_req_cpu(r_pend),
        .i_req_vid(w_req_vid),
        .o_gnt    (w_gnt)
    );

    // RAM port steering from the current grant
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = r_pend_addr;
        ram_wdata = r_pend_wdata;
        vid_ack   = 1'b0;
        case (w_gnt)
            GNT_CPU: begin
                ram_en = 1'b1;
                ram_we = r_pend_we;
            end
            GNT_VID: begin
                ram_en   = 1'b1;
                ram_addr = vid_addr;
                vid_ack  = 1'b1;
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    // CPU pending slot: loaded on capture, drained on CPU grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend       <= 1'b0;
            r_pend_addr  <= {ADDR_W{1'b0}};
            r_pend_we    <= 1'b0;
            r_pend_wdata <= 8'h00;
        end else if (w_capture) begin
            r_pend       <= 1'b1;
            r_pend_addr  <= cpu_addr[ADDR_W-1:0];
            r_pend_we    <= cpu_we;
            r_pend_wdata <= cpu_dout;
        end else if (w_gnt == GNT_CPU) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= r_pend;
        end
    end

    // Return tag, CPU handshake, overrun flag and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag       <= GNT_NONE;
            r_cpu_rdy   <= 1'b1;
            r_cpu_ovr   <= 1'b0;
            r_cpu_din   <= 8'h00;
            r_vid_valid <= 1'b0;
            r_vid_data  <= 8'h00;
        end else begin
            if ((w_gnt == GNT_CPU) && !r_pend_we) begin
                r_tag <= GNT_CPU;
            end else if (w_gnt == GNT_VID) begin
                r_tag <= GNT_VID;
            end else begin
                r_tag <= GNT_NONE;
            end

            // A capture can never coincide with completion: it needs cpu_rdy high.
            if (w_capture) begin
                r_cpu_rdy <= 1'b0;
            end else if ((w_gnt == GNT_CPU) && r_pend_we) begin
                r_cpu_rdy <= 1'b1;
            end else if (r_tag == GNT_CPU) begin
                r_cpu_rdy <= 1'b1;
            end else begin
                r_cpu_rdy <= r_cpu_rdy;
            end

            r_cpu_ovr   <= r_cpu_ovr | w_overrun;
            r_cpu_din   <= (r_tag == GNT_CPU) ? ram_rdata : r_cpu_din;
            r_vid_data  <= (r_tag == GNT_VID) ? ram_rdata : r_vid_data;
            r_vid_valid <= (r_tag == GNT_VID);
        end
    end

    assign cpu_cs    = w_cpu_cs;
    assign cpu_rdy   = r_cpu_rdy;
    assign cpu_ovr   = r_cpu_ovr;
    assign cpu_din   = r_cpu_din;
    assign vid_valid = r_vid_valid;
    assign vid_data  = r_vid_data;

endmodule

// File: tb/tb_tankb_vram_arbiter.sv
// Directed bench: a round-robin instance (a_) and a video-priority instance (b_)
// share all CPU/video inputs, each with its own RAM model.
module tb_tankb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_clken;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic        vid_req;
    logic [9:0]  vid_addr;

    logic [7:0]  a_cpu_din, b_cpu_din, a_vid_data, b_vid_data;
    logic        a_cpu_cs, b_cpu_cs, a_cpu_rdy, b_cpu_rdy, a_cpu_ovr, b_cpu_ovr;
    logic        a_vid_ack, b_vid_ack, a_vid_valid, b_vid_valid;
    logic        a_ram_en, b_ram_en, a_ram_we, b_ram_we;
    logic [9:0]  a_ram_addr, b_ram_addr;
    logic [7:0]  a_ram_wdata, b_ram_wdata, a_ram_rdata, b_ram_rdata;

    logic [7:0]  mem_a [1024];
    logic [7:0]  mem_b [1024];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tankb_vram_arbiter #(.ADDR_W(10), .WIN_BASE(16'h8000), .VID_FIXED_PRI(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .cpu_clken(cpu_clken), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_din(a_cpu_din), .cpu_cs(a_cpu_cs),
        .cpu_rdy(a_cpu_rdy), .cpu_ovr(a_cpu_ovr), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(a_vid_ack), .vid_valid(a_vid_valid), .vid_data(a_vid_data),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
    );

    tankb_vram_arbiter #(.ADDR_W(10), .WIN_BASE(16'h8000), .VID_FIXED_PRI(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .cpu_clken(cpu_clken), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_din(b_cpu_din), .cpu_cs(b_cpu_cs),
        .cpu_rdy(b_cpu_rdy), .cpu_ovr(b_cpu_ovr), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(b_vid_ack), .vid_valid(b_vid_valid), .vid_data(b_vid_data),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // Synchronous single-port RAM models, one-cycle read latency
    always @(posedge clk) begin
        if (a_ram_en) begin
            if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
            a_ram_rdata <= mem_a[a_ram_addr];
        end
        if (b_ram_en) begin
            if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
            b_ram_rdata <= mem_b[b_ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        cpu_clken = 1'b1; cpu_addr = addr; cpu_we = 1'b1; cpu_dout = data;
        step();
        cpu_clken = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; cpu_clken = 1'b0; cpu_addr = 16'h0000; cpu_we = 1'b0;
        cpu_dout = 8'h00; vid_req = 1'b0; vid_addr = 10'h000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdy", {15'd0, a_cpu_rdy}, 16'd1);
        chk("rst_din", {8'd0, a_cpu_din}, 16'h0000);
        chk("rst_ovr", {15'd0, a_cpu_ovr}, 16'd0);
        chk("rst_vvalid", {15'd0, a_vid_valid}, 16'd0);
        chk("rst_ram_en", {15'd0, a_ram_en}, 16'd0);
        chk("rst_ram_we", {15'd0, a_ram_we}, 16'd0);
        reset = 1'b0;
        step();

        // CPU write 0xA5 to 0x8012
        cpu_clken = 1'b1; cpu_addr = 16'h8012; cpu_we = 1'b1; cpu_dout = 8'hA5;
        #1 chk("wr_cs", {15'd0, a_cpu_cs}, 16'd1);
        step();
        cpu_clken = 1'b0;
        chk("wr_rdy_low", {15'd0, a_cpu_rdy}, 16'd0);
        chk("wr_ram_en", {15'd0, a_ram_en}, 16'd1);
        chk("wr_ram_we", {15'd0, a_ram_we}, 16'd1);
        chk("wr_ram_addr", {6'd0, a_ram_addr}, 16'h0012);
        chk("wr_wdata", {8'd0, a_ram_wdata}, 16'h00A5);
        step();
        chk("wr_rdy_back", {15'd0, a_cpu_rdy}, 16'd1);
        chk("wr_idle", {15'd0, a_ram_en}, 16'd0);

        // CPU read back 0x8012: cpu_rdy low for exactly two cycles
        cpu_clken = 1'b1; cpu_we = 1'b0;
        step();
        cpu_clken = 1'b0;
        chk("rd_ram_en", {15'd0, a_ram_en}, 16'd1);
        chk("rd_ram_we", {15'd0, a_ram_we}, 16'd0);
        chk("rd_rdy_c1", {15'd0, a_cpu_rdy}, 16'd0);
        step();
        chk("rd_rdy_c2", {15'd0, a_cpu_rdy}, 16'd0);
        chk("rd_no_issue", {15'd0, a_ram_en}, 16'd0);
        step();
        chk("rd_rdy_c3", {15'd0, a_cpu_rdy}, 16'd1);
        chk("rd_din", {8'd0, a_cpu_din}, 16'h00A5);

        // Window misses just below and just above the 1 KiB window
        for (int i = 0; i < 2; i++) begin
            cpu_clken = 1'b1; cpu_we = 1'b1; cpu_dout = 8'hFF;
            cpu_addr = (i == 0) ? 16'h7FFF : 16'h8400;
            #1 chk("miss_cs", {15'd0, a_cpu_cs}, 16'd0);
            step();
            chk("miss_ram_en", {15'd0, a_ram_en}, 16'd0);
            chk("miss_rdy", {15'd0, a_cpu_rdy}, 16'd1);
        end
        cpu_clken = 1'b0;
        step();

        cpu_write(16'h8100, 8'h5C);
        cpu_write(16'h8200, 8'h3B);

        // Contention: video holds 0x100 while the CPU reads 0x200
        cpu_clken = 1'b1; cpu_addr = 16'h8200; cpu_we = 1'b0;
        vid_req = 1'b1; vid_addr = 10'h100;
        #1 chk("ct0_ack", {15'd0, a_vid_ack}, 16'd1);
        chk("ct0_addr", {6'd0, a_ram_addr}, 16'h0100);
        step();
        cpu_clken = 1'b0;
        chk("ct1_cpu_addr", {6'd0, a_ram_addr}, 16'h0200);
        chk("ct1_ack", {15'd0, a_vid_ack}, 16'd0);
        chk("ct1_en", {15'd0, a_ram_en}, 16'd1);
        chk("fp1_ack", {15'd0, b_vid_ack}, 16'd1);
        chk("fp1_addr", {6'd0, b_ram_addr}, 16'h0100);
        step();
        chk("ct2_vvalid", {15'd0, a_vid_valid}, 16'd1);
        chk("ct2_vdata", {8'd0, a_vid_data}, 16'h005C);
        chk("ct2_ack", {15'd0, a_vid_ack}, 16'd1);
        chk("fp2_ack", {15'd0, b_vid_ack}, 16'd1);
        chk("fp2_rdy", {15'd0, b_cpu_rdy}, 16'd0);
        step();
        chk("ct3_rdy", {15'd0, a_cpu_rdy}, 16'd1);
        chk("ct3_din", {8'd0, a_cpu_din}, 16'h003B);
        chk("ct3_vvalid", {15'd0, a_vid_valid}, 16'd0);
        chk("fp3_rdy", {15'd0, b_cpu_rdy}, 16'd0);
        vid_req = 1'b0;
        #1 chk("ct3_idle", {15'd0, a_ram_en}, 16'd0);
        chk("fp3_cpu_en", {15'd0, b_ram_en}, 16'd1);
        chk("fp3_cpu_addr", {6'd0, b_ram_addr}, 16'h0200);
        chk("fp3_cpu_we", {15'd0, b_ram_we}, 16'd0);
        step();
        chk("ct4_vvalid", {15'd0, a_vid_valid}, 16'd1);
        chk("ct4_vdata", {8'd0, a_vid_data}, 16'h005C);
        chk("fp4_rdy", {15'd0, b_cpu_rdy}, 16'd0);
        step();
        chk("ct5_vvalid", {15'd0, a_vid_valid}, 16'd0);
        chk("fp5_rdy", {15'd0, b_cpu_rdy}, 16'd1);
        chk("fp5_din", {8'd0, b_cpu_din}, 16'h003B);

        // Overrun: second strobe while busy is flagged and dropped
        cpu_clken = 1'b1; cpu_addr = 16'h8001; cpu_we = 1'b1; cpu_dout = 8'h11;
        step();
        cpu_dout = 8'h22;
        chk("ov_busy", {15'd0, a_cpu_rdy}, 16'd0);
        step();
        cpu_clken = 1'b0;
        chk("ov_flag", {15'd0, a_cpu_ovr}, 16'd1);
        chk("ov_rdy", {15'd0, a_cpu_rdy}, 16'd1);
        chk("ov_no_issue", {15'd0, a_ram_en}, 16'd0);
        step();
        chk("ov_sticky", {15'd0, a_cpu_ovr}, 16'd1);
        cpu_clken = 1'b1; cpu_we = 1'b0;
        step();
        cpu_clken = 1'b0;
        step();
        step();
        chk("ov_first_data", {8'd0, a_cpu_din}, 16'h0011);
        chk("ov_still", {15'd0, a_cpu_ovr}, 16'd1);

        // Reset while a CPU read is pending
        cpu_clken = 1'b1; cpu_addr = 16'h8012; cpu_we = 1'b0;
        step();
        cpu_clken = 1'b0;
        chk("mr_pending", {15'd0, a_cpu_rdy}, 16'd0);
        reset = 1'b1;
        #1 chk("mr_rdy", {15'd0, a_cpu_rdy}, 16'd1);
        chk("mr_ram_en", {15'd0, a_ram_en}, 16'd0);
        chk("mr_vvalid", {15'd0, a_vid_valid}, 16'd0);
        chk("mr_ovr", {15'd0, a_cpu_ovr}, 16'd0);
        step();
        reset = 1'b0;
        step();
        chk("mr_after_en", {15'd0, a_ram_en}, 16'd0);
        chk("mr_after_rdy", {15'd0, a_cpu_rdy}, 16'd1);
        chk("mr_after_din", {8'd0, a_cpu_din}, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tankb_vram_arbiter.md
Name: tankb_vram_arbiter

Overview:
- Shares one synchronous single-port RAM (1-cycle read latency, same timing as the program ROM) between the 6502 CPU bus and the video fetch engine.
- Decodes the CPU address window and captures CPU accesses on cpu_clken.
- Arbitrates each RAM cycle between CPU and video, and routes returning read data to the correct requester.
- Drives the CPU ready input so the CPU stalls while its access is pending.

Parameters:
- ADDR_W, 10, RAM address width in bytes-addressed words.
- WIN_BASE, 16'h8000, CPU base address of the RAM window; must be aligned to 2^ADDR_W.
- VID_FIXED_PRI, 0, 0 = round-robin on contention; 1 = video always wins.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_clken  in  1  CPU enable strobe; accesses are sampled only when it is high.
- cpu_addr  in  16  CPU address bus.
- cpu_we  in  1  CPU write strobe, 1 = write.
- cpu_dout  in  8  CPU write data.
- cpu_din  out  8  CPU read data, registered.
- cpu_cs  out  1  combinational window decode: cpu_addr[15:ADDR_W] == WIN_BASE[15:ADDR_W].
- cpu_rdy  out  1  0 while a CPU access is pending or a CPU read is in flight.
- cpu_ovr  out  1  sticky error: a CPU access was presented while busy.
- vid_req  in  1  video read request (level); vid_addr must be held until ack.
- vid_addr  in  ADDR_W  video read address.
- vid_ack  out  1  combinational; high in the cycle the video request is issued to RAM.
- vid_valid  out  1  one-cycle pulse; vid_data is valid.
- vid_data  out  8  video read data, registered.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset values: cpu_din=0, cpu_rdy=1, cpu_ovr=0, vid_valid=0, vid_data=0, ram_en=0, ram_we=0. Pending register and return tag are cleared; last_grant is set to CPU.
- Reset mid-operation drops any pending or in-flight access. No RAM write completes after reset is asserted.
- CPU capture: when cpu_clken & cpu_cs & cpu_rdy, latch addr[ADDR_W-1:0], we and dout into the pending register (pend=1). cpu_rdy drops the next cycle.
- Overrun: cpu_clken & cpu_cs & ~cpu_rdy sets cpu_ovr. That access is ignored. cpu_ovr clears only on reset.
- Issue (every cycle; at most one RAM access per cycle): candidates are pend and vid_req.
  - Only one candidate: it is granted.
  - Both, VID_FIXED_PRI=1: video is granted.
  - Both, VID_FIXED_PRI=0: the requester not equal to last_grant is granted.
  - last_grant updates on every grant.
- A captured CPU access may issue no earlier than the cycle after capture, because pend is registered.
- CPU grant: ram_en=1, ram_we=pend_we, ram_addr and ram_wdata come from the pending register, and pend clears.
  - Write: cpu_rdy returns to 1 the cycle after issue.
  - Read: sets tag=CPU for the following cycle.
- Video grant: ram_en=1, ram_we=0, ram_addr=vid_addr, vid_ack=1; sets tag=VID for the following cycle.
- Return (cycle after a read issue):
  - tag=CPU: cpu_din <= ram_rdata; cpu_rdy returns to 1 the next cycle.
  - tag=VID: vid_data <= ram_rdata; vid_valid=1 for one cycle.
- Back-to-back issue is allowed. The return of access N overlaps the issue of access N+1.
- cpu_din holds its value until the next completed CPU read. CPU writes do not change cpu_din.
- Minimum CPU read latency, capture to cpu_rdy=1, is 3 cycles. The worst case with round-robin under continuous vid_req is 4 cycles.
- Accesses outside the window: cpu_cs=0, no capture, no effect on cpu_rdy.
- ram_wdata is don't-care on reads; drive it from the pending register.

Decomposition:
- Shared package tankb_pkg:
  - grant/tag encoding: GNT_NONE=2'd0, GNT_CPU=2'd1, GNT_VID=2'd2.
  - the default WIN_BASE constant.
- One natural sub-module, tankb_rr_arb2: a 2-way round-robin/fixed-priority arbiter with a last_grant register, instantiated once.
- Capture, issue and return logic stay in the top module.

Test Plan:
- Reset: assert reset mid-read (pend=1, tag=CPU) -> next cycle cpu_rdy=1, ram_en=0, vid_valid=0, cpu_ovr=0.
- CPU write then read, no video: write 8'hA5 to 16'h8012, then read 16'h8012 -> write issues ram_we=1, ram_addr=10'h012, ram_wdata=8'hA5; read returns cpu_din=8'hA5 with cpu_rdy low exactly 2 cycles.
- Window miss: access to 16'h7FFF or 16'h8400 (ADDR_W=10) -> cpu_cs=0, no ram_en, cpu_rdy stays 1.
- Contention, round-robin: vid_req held with vid_addr=10'h100 while the CPU reads 10'h200 -> grants alternate strictly (VID first after a VID-less reset only if pend is absent). CPU read completes within 4 cycles; vid_valid pulses once per vid_ack with correct data.
- VID_FIXED_PRI=1 with continuous vid_req -> CPU never issues and cpu_rdy stays 0. When vid_req drops, the CPU issues the next cycle.
- Overrun: second cpu_clken access to 16'h8001 while cpu_rdy=0 -> cpu_ovr=1 and stays 1. The first access completes normally; the second generates no ram_en.
